// File: rtl/adc_sample_collector.sv
// Polls the sequence counters of the masked ADC channels over a simple read bus and
// queues every fresh sample, tagged with its channel, in a show-ahead FIFO.
module adc_sample_collector #(
  parameter logic [10:0] ADC_POSITION = 11'h000,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  channel_mask,
  output logic [18:0] adc_addr,
  output logic        adc_re,
  input  logic [15:0] adc_data,
  input  logic        rd_en,
  output logic [15:0] fifo_data,
  output logic [2:0]  fifo_chan,
  output logic        fifo_empty,
  output logic [4:0]  fifo_count,
  output logic        overflow,
  output logic        missed,
  input  logic        clear_flags
);

  localparam logic [3:0] CMD_SEQUENCE = 4'h8;
  localparam logic [3:0] CMD_SAMPLE   = 4'h7;
  localparam int         AW           = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH        = 5'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SEQ_REQ, SEQ_WAIT, SAMP_REQ, SAMP_WAIT, PUSH, NEXT
  } state_t;

  typedef struct packed {
    logic [2:0]  chan;
    logic [15:0] data;
  } entry_t;

  state_t          state;
  logic [2:0]      cur_ch;
  logic [15:0]     new_seq;
  logic [15:0]     sample;
  logic [15:0]     last_seq [8];
  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      count;
  logic [2:0]      first_ch, following_ch;
  logic [15:0]     seq_step;
  logic            do_push, do_pop, full;

  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) lowest_set = 3'(i);
  endfunction

  // Scans the offsets farthest-first so the nearest set bit above 'from' wins;
  // offset 0 (from itself) is the fallback when it is the only set bit.
  function automatic logic [2:0] next_set(input logic [7:0] mask, input logic [2:0] from);
    logic [2:0] c;
    next_set = from;
    for (int i = 7; i >= 1; i--) begin
      c = from + 3'(i);
      if (mask[c]) next_set = c;
    end
  endfunction

  assign first_ch     = lowest_set(channel_mask);
  assign following_ch = next_set(channel_mask, cur_ch);
  assign seq_step     = new_seq - last_seq[cur_ch];
  assign full         = (count == DEPTH);
  assign do_pop       = rd_en && (count != 5'd0);
  assign do_push      = (state == PUSH) && (!full || rd_en);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update together on the edge and no read depends on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_ch   <= '0;
      adc_re   <= 1'b0;
      adc_addr <= '0;
      new_seq  <= '0;
      sample   <= '0;
      overflow <= 1'b0;
      missed   <= 1'b0;
      for (int i = 0; i < 8; i++) last_seq[i] <= '0;
    end else begin
      adc_re <= 1'b0;
      // Clearing comes first so a flag set later in this cycle takes priority.
      if (clear_flags) begin
        overflow <= 1'b0;
        missed   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (enable && (channel_mask != 8'h00)) begin
            cur_ch   <= first_ch;
            adc_re   <= 1'b1;
            adc_addr <= {ADC_POSITION, 1'b0, first_ch, CMD_SEQUENCE};
            state    <= SEQ_REQ;
          end
        end
        SEQ_REQ: state <= SEQ_WAIT;
        SEQ_WAIT: begin
          new_seq <= adc_data;
          if (adc_data != last_seq[cur_ch]) begin
            adc_re   <= 1'b1;
            adc_addr <= {ADC_POSITION, 1'b0, cur_ch, CMD_SAMPLE};
            state    <= SAMP_REQ;
          end else begin
            state <= NEXT;
          end
        end
        SAMP_REQ: state <= SAMP_WAIT;
        SAMP_WAIT: begin
          sample <= adc_data;
          state  <= PUSH;
        end
        PUSH: begin
          if (!do_push) overflow <= 1'b1;
          if (seq_step > 16'd1) missed <= 1'b1;
          last_seq[cur_ch] <= new_seq;
          state            <= NEXT;
        end
        NEXT: begin
          if (channel_mask != 8'h00) cur_ch <= following_ch;
          if (enable && (channel_mask != 8'h00)) begin
            adc_re   <= 1'b1;
            adc_addr <= {ADC_POSITION, 1'b0, following_ch, CMD_SEQUENCE};
            state    <= SEQ_REQ;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + 5'(do_push) - 5'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; entries are only visible once written,
  // and the head is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= '{chan: cur_ch, data: sample};
  end

  assign fifo_empty = (count == 5'd0);
  assign fifo_count = count;
  assign fifo_data  = fifo_empty ? 16'h0000 : mem[rd_ptr].data;
  assign fifo_chan  = fifo_empty ? 3'd0     : mem[rd_ptr].chan;

endmodule
